l1d_access_scheduler: RTL and testbench
=======================================

# l1d_access_scheduler

Issue scheduler in front of the dual-port `l1d_Cache`. It accepts load/store micro-ops from two execution pipes through valid/ready handshakes and buffers each pipe in a small FIFO. Each cycle it issues the FIFO heads to cache ports A and B, serializing same-line hazards and squashing out-of-range accesses. It sits between the execute stage and the cache. Its outputs connect one-to-one to the cache's `loadStore*_i / opCode*_i / pOperand*_i / sOperand*_i / isWb*_i / wbAddress*_i` inputs.

## Interface
- `DEPTH`, 2: entries per requester FIFO (power of two, ≥2).
- `NUM_LINES`, 4000: valid cache indices 0..NUM_LINES-1.
- `clock_i` in 1: single clock, rising edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `reqValidA_i`, `reqValidB_i` in 1: request present on pipe A / B.
- `reqReadyA_o`, `reqReadyB_o` out 1: FIFO not full; a transfer occurs when valid & ready at a rising edge.
- `opCodeA_i`, `opCodeB_i` in 7: 0 nop, 10 immediate-to-reg, 11 load, 12 store.
- `pOperandA_i`, `pOperandB_i`, `sOperandA_i`, `sOperandB_i` in 16: store data / address-or-immediate.
- `isWbA_i`, `isWbB_i` in 1; `wbAddressA_i`, `wbAddressB_i` in 5: writeback tag, passed through.
- `stall_i` in 1: downstream hold; no issue while high.
- `loadStoreA_o`, `loadStoreB_o` out 1: issue strobe to the cache port.
- `opCodeA_o`, `opCodeB_o` out 7; `pOperand*_o`, `sOperand*_o` out 16; `isWb*_o` out 1; `wbAddress*_o` out 5: issued fields.
- `rangeError_o` out 1: sticky; set when any load/store with `sOperand ≥ NUM_LINES` is issued.
- `conflictCount_o` out 16: saturating count of cycles in which B was held for a hazard.

## Operation
- Two independent FIFOs, A and B, each `DEPTH` entries. Each entry holds {opCode, pOperand, sOperand, isWb, wbAddress}.
- `reqReady*_o = (count < DEPTH)`. The output is combinational from the registered count, so a full FIFO cannot accept a push even when it pops in the same cycle.
- The head of A is always treated as older than the head of B.
- A memory op is opcode 11 or 12.
- Hazard: both heads present, both memory ops, equal `sOperand`, and at least one is a store (12).
- Issue decision per cycle, when `stall_i` = 0:
  - A non-empty: pop A and issue it on port A.
  - B non-empty and no hazard: pop B and issue it on port B.
  - Hazard: issue A only. B stays at its head and `conflictCount_o` increments, saturating at 16'hFFFF.
  - A empty, B non-empty: B issues; no hazard is possible.
- Range squash: an issued memory op with `sOperand ≥ NUM_LINES` goes out with opcode 0, `isWb` 0 and `loadStore*_o` 1. It sets `rangeError_o`, which stays set until reset.
- Opcodes outside {0, 10, 11, 12} are passed through unchanged; the cache ignores them.
- `stall_i` = 1: no pops, `loadStore*_o` = 0, and the other outputs hold their values. Pushes continue while the FIFOs have space.
- Push and pop on the same FIFO in the same cycle leave the count unchanged. Pointers wrap modulo `DEPTH`.

## Timing
- All outputs are registered.
- A request accepted at edge N can issue at edge N+1 at the earliest, so it is visible on the outputs after edge N+1 (1-cycle latency through an empty FIFO).
- A request held for a hazard issues one cycle after its partner, provided no stall occurs.
- Reset (asynchronous, any time, including mid-stream):
  - FIFOs are emptied and in-flight entries are discarded.
  - `reqReady*_o` = 1 (combinational from count = 0).
  - All other outputs are 0: `loadStore*_o`, `opCode*_o`, `pOperand*_o`, `sOperand*_o`, `isWb*_o`, `wbAddress*_o`, `rangeError_o`, `conflictCount_o`.
- The first issue can occur one edge after the first accept following release of reset.
- Throughput: 2 ops/cycle with no hazards; 1 op/cycle on back-to-back hazards.

## Test plan
- Reset, then push A = {12, p=16'h00AA, s=5} and B = {11, s=9} in the same cycle. Next edge: both ports strobe with the fields unchanged; `conflictCount_o` = 0.
- Push A = {12, s=7} and B = {11, s=7}. First issue: A only. Following cycle: B issues on port B. `conflictCount_o` = 1.
- Push A = {11, s=3} and B = {11, s=3}. Load-load is not a hazard: both issue in the same cycle.
- Push A = {11, s=4000}. Port A issues opcode 0 with `isWb` 0, and `rangeError_o` = 1 and stays set through later traffic.
- Hold `stall_i` = 1 and push three requests on A: `reqReadyA_o` drops after two. Release the stall: they issue one per cycle in push order, and `reqReadyA_o` returns high.
- Assert `reset_i` mid-stream with both FIFOs full. All outputs clear immediately without waiting for a clock edge. Nothing issues after reset is released.

Source files
------------

// File: rtl/l1d_access_scheduler.sv
// l1d_access_scheduler: issue stage in front of the dual-port l1d_Cache.
// Each execution pipe has its own small FIFO. Every unstalled cycle the FIFO
// heads are issued to cache ports A and B. When the heads touch the same line
// and at least one of them is a store, port B is held back for one cycle.
// Memory ops that address a line past the end of the cache are squashed to NOPs.
module l1d_access_scheduler #(
  parameter int DEPTH     = 2,
  parameter int NUM_LINES = 4000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        reqValidA_i,
  input  logic        reqValidB_i,
  output logic        reqReadyA_o,
  output logic        reqReadyB_o,
  input  logic [6:0]  opCodeA_i,
  input  logic [6:0]  opCodeB_i,
  input  logic [15:0] pOperandA_i,
  input  logic [15:0] pOperandB_i,
  input  logic [15:0] sOperandA_i,
  input  logic [15:0] sOperandB_i,
  input  logic        isWbA_i,
  input  logic        isWbB_i,
  input  logic [4:0]  wbAddressA_i,
  input  logic [4:0]  wbAddressB_i,
  input  logic        stall_i,
  output logic        loadStoreA_o,
  output logic        loadStoreB_o,
  output logic [6:0]  opCodeA_o,
  output logic [6:0]  opCodeB_o,
  output logic [15:0] pOperandA_o,
  output logic [15:0] pOperandB_o,
  output logic [15:0] sOperandA_o,
  output logic [15:0] sOperandB_o,
  output logic        isWbA_o,
  output logic        isWbB_o,
  output logic [4:0]  wbAddressA_o,
  output logic [4:0]  wbAddressB_o,
  output logic        rangeError_o,
  output logic [15:0] conflictCount_o
);

  localparam int          PTR_W      = $clog2(DEPTH);
  localparam int          CNT_W      = $clog2(DEPTH + 1);
  localparam logic [16:0] LINE_LIMIT = 17'(NUM_LINES);
  localparam logic [6:0]  OP_NOP     = 7'd0;
  localparam logic [6:0]  OP_LOAD    = 7'd11;
  localparam logic [6:0]  OP_STORE   = 7'd12;

  typedef struct packed {
    logic [6:0]  opCode;
    logic [15:0] pOperand;
    logic [15:0] sOperand;
    logic        isWb;
    logic [4:0]  wbAddress;
  } entry_t;

  function automatic logic isMemOp(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Index 0 is pipe/port A, index 1 is pipe/port B.
  entry_t [1:0] reqEntry;
  entry_t [1:0] headEntry;
  entry_t [1:0] issueEntry;
  logic   [1:0] reqValid;
  logic   [1:0] reqReady;
  logic   [1:0] notEmpty;
  logic   [1:0] pop;
  logic   [1:0] rangeHit;
  logic   [1:0] issueStrobe;
  logic         hazard;
  logic         rangeErrorReg;
  logic [15:0]  conflictCountReg;

  assign reqEntry[0] = {opCodeA_i, pOperandA_i, sOperandA_i, isWbA_i, wbAddressA_i};
  assign reqEntry[1] = {opCodeB_i, pOperandB_i, sOperandB_i, isWbB_i, wbAddressB_i};
  assign reqValid    = {reqValidB_i, reqValidA_i};

  // Same-line hazard between the two heads; A is always the older request,
  // so it is B that waits.
  assign hazard = notEmpty[0] && notEmpty[1]
               && isMemOp(headEntry[0].opCode) && isMemOp(headEntry[1].opCode)
               && (headEntry[0].sOperand == headEntry[1].sOperand)
               && ((headEntry[0].opCode == OP_STORE) || (headEntry[1].opCode == OP_STORE));

  assign pop[0] = !stall_i && notEmpty[0];
  assign pop[1] = !stall_i && notEmpty[1] && !hazard;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pipe
      logic [PTR_W-1:0] wrPtrReg;
      logic [PTR_W-1:0] rdPtrReg;
      logic [CNT_W-1:0] countReg;
      entry_t           mem [DEPTH];
      entry_t           squashed;
      entry_t           issueReg;
      logic             loadStoreReg;
      logic             outOfRange;
      logic             push;

      // Ready comes from the registered count only, so a full FIFO refuses a
      // push even in a cycle where it also pops.
      assign reqReady[gi]  = countReg < CNT_W'(DEPTH);
      assign notEmpty[gi]  = countReg != '0;
      assign push          = reqValid[gi] && reqReady[gi];
      assign headEntry[gi] = mem[rdPtrReg];

      // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
      always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
          wrPtrReg <= '0;
          rdPtrReg <= '0;
          countReg <= '0;
        end else begin
          if (push)   wrPtrReg <= wrPtrReg + 1'b1;
          if (pop[gi]) rdPtrReg <= rdPtrReg + 1'b1;
          case ({push, pop[gi]})
            2'b10:   countReg <= countReg + 1'b1;
            2'b01:   countReg <= countReg - 1'b1;
            default: countReg <= countReg;
          endcase
        end
      end

      // FIFO storage; contents need no reset because occupancy gates every read.
      always_ff @(posedge clock_i) begin
        if (push) mem[wrPtrReg] <= reqEntry[gi];
      end

      // Out-of-range memory ops become NOPs without writeback, keeping their operands.
      always_comb begin
        outOfRange = isMemOp(headEntry[gi].opCode)
                  && ({1'b0, headEntry[gi].sOperand} >= LINE_LIMIT);
        squashed   = headEntry[gi];
        if (outOfRange) begin
          squashed.opCode = OP_NOP;
          squashed.isWb   = 1'b0;
        end
      end

      assign rangeHit[gi] = pop[gi] && outOfRange;

      // Issue register for this cache port: strobe for one cycle per pop, fields hold otherwise.
      always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
          loadStoreReg <= 1'b0;
          issueReg     <= '0;
        end else if (pop[gi]) begin
          loadStoreReg <= 1'b1;
          issueReg     <= squashed;
        end else begin
          loadStoreReg <= 1'b0;
        end
      end

      assign issueEntry[gi]  = issueReg;
      assign issueStrobe[gi] = loadStoreReg;
    end
  endgenerate

  // Sticky range error and saturating count of cycles where B was held by a hazard.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rangeErrorReg    <= 1'b0;
      conflictCountReg <= '0;
    end else begin
      if (|rangeHit) rangeErrorReg <= 1'b1;
      if (!stall_i && hazard && (conflictCountReg != 16'hFFFF))
        conflictCountReg <= conflictCountReg + 16'd1;
    end
  end

  assign reqReadyA_o     = reqReady[0];
  assign reqReadyB_o     = reqReady[1];
  assign loadStoreA_o    = issueStrobe[0];
  assign loadStoreB_o    = issueStrobe[1];
  assign opCodeA_o       = issueEntry[0].opCode;
  assign opCodeB_o       = issueEntry[1].opCode;
  assign pOperandA_o     = issueEntry[0].pOperand;
  assign pOperandB_o     = issueEntry[1].pOperand;
  assign sOperandA_o     = issueEntry[0].sOperand;
  assign sOperandB_o     = issueEntry[1].sOperand;
  assign isWbA_o         = issueEntry[0].isWb;
  assign isWbB_o         = issueEntry[1].isWb;
  assign wbAddressA_o    = issueEntry[0].wbAddress;
  assign wbAddressB_o    = issueEntry[1].wbAddress;
  assign rangeError_o    = rangeErrorReg;
  assign conflictCount_o = conflictCountReg;

endmodule

// File: tb/tb_l1d_access_scheduler.sv
// Bench for l1d_access_scheduler: directed scenarios followed by random
// traffic, all checked against a queue-based model of the issue rules.
module tb_l1d_access_scheduler;

  localparam int DEPTH     = 2;
  localparam int NUM_LINES = 4000;

  typedef struct packed {
    logic [6:0]  op;
    logic [15:0] p;
    logic [15:0] s;
    logic        wb;
    logic [4:0]  addr;
  } tb_entry_t;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        reqValidA_i = 1'b0, reqValidB_i = 1'b0;
  logic        reqReadyA_o, reqReadyB_o;
  logic [6:0]  opCodeA_i = '0, opCodeB_i = '0;
  logic [15:0] pOperandA_i = '0, pOperandB_i = '0, sOperandA_i = '0, sOperandB_i = '0;
  logic        isWbA_i = 1'b0, isWbB_i = 1'b0;
  logic [4:0]  wbAddressA_i = '0, wbAddressB_i = '0;
  logic        stall_i = 1'b0;
  logic        loadStoreA_o, loadStoreB_o;
  logic [6:0]  opCodeA_o, opCodeB_o;
  logic [15:0] pOperandA_o, pOperandB_o, sOperandA_o, sOperandB_o;
  logic        isWbA_o, isWbB_o;
  logic [4:0]  wbAddressA_o, wbAddressB_o;
  logic        rangeError_o;
  logic [15:0] conflictCount_o;

  l1d_access_scheduler #(.DEPTH(DEPTH), .NUM_LINES(NUM_LINES)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .reqValidA_i(reqValidA_i), .reqValidB_i(reqValidB_i),
    .reqReadyA_o(reqReadyA_o), .reqReadyB_o(reqReadyB_o),
    .opCodeA_i(opCodeA_i), .opCodeB_i(opCodeB_i),
    .pOperandA_i(pOperandA_i), .pOperandB_i(pOperandB_i),
    .sOperandA_i(sOperandA_i), .sOperandB_i(sOperandB_i),
    .isWbA_i(isWbA_i), .isWbB_i(isWbB_i),
    .wbAddressA_i(wbAddressA_i), .wbAddressB_i(wbAddressB_i),
    .stall_i(stall_i),
    .loadStoreA_o(loadStoreA_o), .loadStoreB_o(loadStoreB_o),
    .opCodeA_o(opCodeA_o), .opCodeB_o(opCodeB_o),
    .pOperandA_o(pOperandA_o), .pOperandB_o(pOperandB_o),
    .sOperandA_o(sOperandA_o), .sOperandB_o(sOperandB_o),
    .isWbA_o(isWbA_o), .isWbB_o(isWbB_o),
    .wbAddressA_o(wbAddressA_o), .wbAddressB_o(wbAddressB_o),
    .rangeError_o(rangeError_o), .conflictCount_o(conflictCount_o)
  );

  always #5 clock_i = ~clock_i;

  int testsRun  = 0;
  int failCount = 0;

  // Reference model state: pending requests per pipe and the expected outputs.
  tb_entry_t qA[$];
  tb_entry_t qB[$];
  tb_entry_t expOutA, expOutB;
  bit        expLsA, expLsB, expRange;
  int        expConflict;
  tb_entry_t idleEntry;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic tb_entry_t mk(input int op, input int p, input int s, input bit wb, input int addr);
    tb_entry_t e;
    e.op = 7'(op); e.p = 16'(p); e.s = 16'(s); e.wb = wb; e.addr = 5'(addr);
    return e;
  endfunction

  function automatic bit isMem(input logic [6:0] op);
    return (op == 7'd11) || (op == 7'd12);
  endfunction

  function automatic bit outOfRange(input tb_entry_t e);
    return isMem(e.op) && (int'(e.s) >= NUM_LINES);
  endfunction

  function automatic tb_entry_t squash(input tb_entry_t e);
    tb_entry_t r = e;
    if (outOfRange(e)) begin
      r.op = 7'd0;
      r.wb = 1'b0;
    end
    return r;
  endfunction

  task automatic modelReset();
    qA.delete(); qB.delete();
    expOutA = '0; expOutB = '0;
    expLsA = 0; expLsB = 0; expRange = 0; expConflict = 0;
  endtask

  // One rising edge of the model: heads issue (older A first), then accepted requests join the queues.
  task automatic modelEdge(input bit vA, input tb_entry_t eA, input bit vB, input tb_entry_t eB, input bit st);
    bit accA, accB, haz;
    tb_entry_t e;
    accA = vA && (qA.size() < DEPTH);
    accB = vB && (qB.size() < DEPTH);
    haz = (qA.size() > 0) && (qB.size() > 0) && isMem(qA[0].op) && isMem(qB[0].op)
          && (qA[0].s == qB[0].s) && ((qA[0].op == 7'd12) || (qB[0].op == 7'd12));
    expLsA = 0;
    expLsB = 0;
    if (!st) begin
      if (qA.size() > 0) begin
        e = qA.pop_front();
        if (outOfRange(e)) expRange = 1;
        expOutA = squash(e);
        expLsA = 1;
      end
      if ((qB.size() > 0) && !haz) begin
        e = qB.pop_front();
        if (outOfRange(e)) expRange = 1;
        expOutB = squash(e);
        expLsB = 1;
      end
      if (haz && expConflict < 65535) expConflict++;
    end
    if (accA) qA.push_back(eA);
    if (accB) qB.push_back(eB);
  endtask

  task automatic checkOutputs(input string tag);
    chk({tag, ".portA"}, 64'({loadStoreA_o, opCodeA_o, pOperandA_o, sOperandA_o, isWbA_o, wbAddressA_o}),
        64'({expLsA, expOutA}));
    chk({tag, ".portB"}, 64'({loadStoreB_o, opCodeB_o, pOperandB_o, sOperandB_o, isWbB_o, wbAddressB_o}),
        64'({expLsB, expOutB}));
    chk({tag, ".rangeError"}, 64'(rangeError_o), 64'(expRange));
    chk({tag, ".conflictCount"}, 64'(conflictCount_o), 64'(expConflict));
  endtask

  // One clock cycle: drive at the falling edge, check ready, then check outputs just after the rising edge.
  task automatic step(input bit vA, input tb_entry_t eA, input bit vB, input tb_entry_t eB, input bit st);
    @(negedge clock_i);
    reqValidA_i = vA; opCodeA_i = eA.op; pOperandA_i = eA.p; sOperandA_i = eA.s;
    isWbA_i = eA.wb; wbAddressA_i = eA.addr;
    reqValidB_i = vB; opCodeB_i = eB.op; pOperandB_i = eB.p; sOperandB_i = eB.s;
    isWbB_i = eB.wb; wbAddressB_i = eB.addr;
    stall_i = st;
    chk("readyA", 64'(reqReadyA_o), 64'(qA.size() < DEPTH));
    chk("readyB", 64'(reqReadyB_o), 64'(qB.size() < DEPTH));
    @(posedge clock_i);
    modelEdge(vA, eA, vB, eB, st);
    #1;
    checkOutputs("cycle");
    $display("[TB] t=%0t pushA=%0b pushB=%0b stall=%0b | issueA=%0b op=%0d s=%0d | issueB=%0b op=%0d s=%0d | conflicts=%0d",
             $time, vA, vB, st, loadStoreA_o, opCodeA_o, sOperandA_o, loadStoreB_o, opCodeB_o, sOperandB_o,
             conflictCount_o);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, idleEntry, 0, idleEntry, 0);
  endtask

  function automatic tb_entry_t randEntry();
    tb_entry_t e;
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 3)      e.op = 7'd11;
    else if (r <= 6) e.op = 7'd12;
    else if (r == 7) e.op = 7'd10;
    else if (r == 8) e.op = 7'd0;
    else             e.op = 7'($urandom_range(13, 127));
    r = int'($urandom_range(0, 19));
    if (r == 0)      e.s = 16'd4000;
    else if (r == 1) e.s = 16'd3999;
    else if (r == 2) e.s = 16'hFFFF;
    else             e.s = 16'($urandom_range(0, 3));
    e.p    = 16'($urandom);
    e.wb   = 1'($urandom);
    e.addr = 5'($urandom);
    return e;
  endfunction

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tb_entry_t a1, a2, a3;
    idleEntry = '0;
    modelReset();

    // Reset state.
    @(negedge clock_i);
    @(negedge clock_i);
    checkOutputs("reset");
    chk("reset.readyA", 64'(reqReadyA_o), 64'd1);
    chk("reset.readyB", 64'(reqReadyB_o), 64'd1);
    reset_i = 1'b0;

    // Store A and load B on different lines issue together, fields unchanged.
    step(1, mk(12, 16'h00AA, 5, 1, 3), 1, mk(11, 16'h0011, 9, 1, 4), 0);
    idle(1);
    chk("t1.lsA", 64'(loadStoreA_o), 64'd1);
    chk("t1.lsB", 64'(loadStoreB_o), 64'd1);
    chk("t1.opA", 64'(opCodeA_o), 64'd12);
    chk("t1.pA", 64'(pOperandA_o), 64'h00AA);
    chk("t1.sB", 64'(sOperandB_o), 64'd9);
    chk("t1.conflict", 64'(conflictCount_o), 64'd0);

    // Store/load on the same line: A first, B one cycle later.
    step(1, mk(12, 16'h1234, 7, 0, 1), 1, mk(11, 16'h5678, 7, 1, 2), 0);
    idle(1);
    chk("t2.lsA", 64'(loadStoreA_o), 64'd1);
    chk("t2.lsB held", 64'(loadStoreB_o), 64'd0);
    idle(1);
    chk("t2.lsB", 64'(loadStoreB_o), 64'd1);
    chk("t2.sB", 64'(sOperandB_o), 64'd7);
    chk("t2.conflict", 64'(conflictCount_o), 64'd1);

    // Load/load on the same line is not a hazard.
    step(1, mk(11, 16'h0001, 3, 1, 5), 1, mk(11, 16'h0002, 3, 1, 6), 0);
    idle(1);
    chk("t3.both", 64'({loadStoreA_o, loadStoreB_o}), 64'b11);
    chk("t3.conflict", 64'(conflictCount_o), 64'd1);

    // Out-of-range load is squashed and the error is sticky.
    step(1, mk(11, 16'h0BAD, 4000, 1, 7), 0, idleEntry, 0);
    idle(1);
    chk("t4.lsA", 64'(loadStoreA_o), 64'd1);
    chk("t4.opA", 64'(opCodeA_o), 64'd0);
    chk("t4.wbA", 64'(isWbA_o), 64'd0);
    chk("t4.sA", 64'(sOperandA_o), 64'd4000);
    chk("t4.range", 64'(rangeError_o), 64'd1);
    step(1, mk(12, 16'h0001, 10, 1, 1), 1, mk(11, 16'h0002, 11, 1, 2), 0);
    idle(2);
    chk("t4.range sticky", 64'(rangeError_o), 64'd1);

    // Stall: the FIFO fills after two pushes, then drains in order.
    a1 = mk(10, 16'hA001, 20, 1, 1);
    a2 = mk(11, 16'hA002, 21, 1, 2);
    a3 = mk(12, 16'hA003, 22, 1, 3);
    step(1, a1, 0, idleEntry, 1);
    step(1, a2, 0, idleEntry, 1);
    step(1, a3, 0, idleEntry, 1);
    chk("t5.full", 64'(reqReadyA_o), 64'd0);
    chk("t5.ls stalled", 64'(loadStoreA_o), 64'd0);
    idle(1);
    chk("t5.first", 64'({loadStoreA_o, pOperandA_o}), 64'({1'b1, 16'hA001}));
    idle(1);
    chk("t5.second", 64'({loadStoreA_o, pOperandA_o}), 64'({1'b1, 16'hA002}));
    chk("t5.ready back", 64'(reqReadyA_o), 64'd1);
    idle(1);
    chk("t5.third rejected", 64'(loadStoreA_o), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), randEntry(), ($urandom_range(0, 3) != 0), randEntry(),
           ($urandom_range(0, 4) == 0));
    end
    idle(3);

    // Asynchronous reset mid-stream with both FIFOs full.
    step(1, mk(12, 16'hBEEF, 1, 1, 9), 1, mk(11, 16'hCAFE, 2, 1, 8), 0);
    step(1, mk(11, 16'h1111, 3, 1, 9), 1, mk(12, 16'h2222, 4, 1, 8), 1);
    step(1, mk(11, 16'h3333, 5, 1, 9), 1, mk(12, 16'h4444, 6, 1, 8), 1);
    chk("t6.full", 64'({reqReadyA_o, reqReadyB_o}), 64'b00);
    @(negedge clock_i);
    reqValidA_i = 1'b0; reqValidB_i = 1'b0; stall_i = 1'b0;
    #2;
    reset_i = 1'b1;
    #1;
    modelReset();
    checkOutputs("asyncReset");
    chk("asyncReset.readyA", 64'(reqReadyA_o), 64'd1);
    chk("asyncReset.readyB", 64'(reqReadyB_o), 64'd1);
    @(negedge clock_i);
    reset_i = 1'b0;
    idle(3);
    chk("t6.nothing issued", 64'({loadStoreA_o, loadStoreB_o}), 64'b00);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
